// File: rtl/cheat_pkg.sv
// Shared types and layout constants for the cheat-code loader.
package cheat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COLLECT,
    ST_STB_HI,
    ST_STB_LO
  } state_t;

  localparam int FLAGS_S      = 96;
  localparam int ADDR_S       = 64;
  localparam int COMP_S       = 32;
  localparam int DATA_S       = 0;
  localparam int CLK_BIT      = 128;
  localparam int RECORD_WORDS = 8;

  // Bit offset of record word k: field k/2 counts down from flags, half k%2 selects the upper 16 bits.
  function automatic int word_offset(input logic [2:0] k);
    return FLAGS_S - 32 * int'(k[2:1]) + 16 * int'(k[0]);
  endfunction

endpackage

// File: rtl/edge_rise.sv
// One-register rising-edge detector.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // Remember last cycle's level so a 0->1 change can be spotted.
  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/cheat_loader.sv
// Assembles 16-bit download words into 129-bit cheat records and strobes them into the engine.
module cheat_loader
  import cheat_pkg::*;
#(
  parameter int MAX_CODES     = 32,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ioctl_download,
  input  logic                           ioctl_wr,
  input  logic [15:0]                    ioctl_dout,
  input  logic                           cheat_clear,
  output logic                           ioctl_wait,
  output logic [128:0]                   code,
  output logic                           codes_reset,
  output logic [$clog2(MAX_CODES+1)-1:0] code_count,
  output logic                           overflow
);

  localparam int CW = $clog2(MAX_CODES + 1);
  localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(MAX_CODES);
  localparam logic [SW-1:0] STB_LAST  = SW'(STROBE_CYCLES - 1);
  localparam logic [2:0]    LAST_WORD = 3'(RECORD_WORDS - 1);

  state_t          state;
  logic [2:0]      word_cnt;
  logic [SW-1:0]   stb_cnt;
  logic [127:0]    record;
  logic            code_clk;
  logic            clear_pending;
  logic            dl_rise;
  logic            clr_rise;
  logic            clear_req;
  logic            last_word_wr;
  logic            can_strobe;
  logic [6:0]      word_base;

  edge_rise u_dl_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (ioctl_download),
    .rise  (dl_rise)
  );

  edge_rise u_clr_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (cheat_clear),
    .rise  (clr_rise)
  );

  assign clear_req    = dl_rise | clr_rise | clear_pending;
  assign last_word_wr = ioctl_wr && (word_cnt == LAST_WORD);
  assign can_strobe   = (code_count < COUNT_MAX);
  assign word_base    = 7'(word_offset(word_cnt));

  // The HPS must hold off from the moment the final word of a strobed record lands until the strobe is over.
  assign ioctl_wait = (state == ST_STB_HI) || (state == ST_STB_LO) ||
                      ((state == ST_COLLECT) && ioctl_download && !clear_req &&
                       last_word_wr && can_strobe);

  assign code[CLK_BIT]     = code_clk;
  assign code[CLK_BIT-1:0] = record;

  // Sequencer: clear handling, word collection and the high/low clock-bit strobe, all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      word_cnt      <= 3'd0;
      stb_cnt       <= '0;
      record        <= '0;
      code_clk      <= 1'b0;
      codes_reset   <= 1'b0;
      code_count    <= '0;
      overflow      <= 1'b0;
      clear_pending <= 1'b0;
    end else begin
      codes_reset <= 1'b0;
      if (dl_rise || clr_rise) clear_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state         <= ST_CLEAR;
            codes_reset   <= 1'b1;
            clear_pending <= 1'b0;
            word_cnt      <= 3'd0;
            code_count    <= '0;
            overflow      <= 1'b0;
          end
        end

        ST_CLEAR: begin
          state <= ioctl_download ? ST_COLLECT : ST_IDLE;
        end

        ST_COLLECT: begin
          if (!ioctl_download) begin
            state    <= ST_IDLE;
            word_cnt <= 3'd0;
          end else if (clear_req) begin
            state         <= ST_CLEAR;
            codes_reset   <= 1'b1;
            clear_pending <= 1'b0;
            word_cnt      <= 3'd0;
            code_count    <= '0;
            overflow      <= 1'b0;
          end else if (ioctl_wr) begin
            record[word_base +: 16] <= ioctl_dout;
            word_cnt                <= word_cnt + 3'd1;
            if (word_cnt == LAST_WORD) begin
              if (can_strobe) begin
                state    <= ST_STB_HI;
                code_clk <= 1'b1;
                stb_cnt  <= '0;
              end else begin
                overflow <= 1'b1;
              end
            end
          end
        end

        ST_STB_HI: begin
          if (stb_cnt == STB_LAST) begin
            state      <= ST_STB_LO;
            code_clk   <= 1'b0;
            stb_cnt    <= '0;
            code_count <= code_count + 1'b1;
          end else begin
            stb_cnt <= stb_cnt + 1'b1;
          end
        end

        ST_STB_LO: begin
          if (stb_cnt == STB_LAST) begin
            state   <= ioctl_download ? ST_COLLECT : ST_IDLE;
            stb_cnt <= '0;
          end else begin
            stb_cnt <= stb_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cheat_loader.sv
// Scoreboard testbench for cheat_loader with a file-format reference model.
module tb_cheat_loader;

  localparam int MAXC = 32;
  localparam int STB  = 2;
  localparam int CW   = $clog2(MAXC + 1);

  typedef struct {
    logic [127:0] rec;
    int           cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [15:0]   ioctl_dout = 16'h0;
  logic          cheat_clear = 1'b0;
  logic          ioctl_wait;
  logic [128:0]  code;
  logic          codes_reset;
  logic [CW-1:0] code_count;
  logic          overflow;

  int total = 0;
  int bad = 0;
  int model_count = 0;
  bit model_overflow = 0;
  int exp_clears = 0;
  int clr_pulses = 0;
  int strobes_seen = 0;
  logic [15:0] words[$];
  exp_t exp_q[$];

  cheat_loader #(.MAX_CODES(MAXC), .STROBE_CYCLES(STB)) dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .cheat_clear    (cheat_clear),
    .ioctl_wait     (ioctl_wait),
    .code           (code),
    .codes_reset    (codes_reset),
    .code_count     (code_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // Single comparison point shared by stimulus and monitor.
  task automatic check_output(input string name, input logic [128:0] act, input logic [128:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Record image as the file defines it: four little-endian 32-bit fields, flags first.
  function automatic logic [127:0] assemble();
    logic [31:0] flags, addr, comp, repl;
    flags = {words[1], words[0]};
    addr  = {words[3], words[2]};
    comp  = {words[5], words[4]};
    repl  = {words[7], words[6]};
    return {flags, addr, comp, repl};
  endfunction

  // mode 0: plain word, 1: pulse cheat_clear during the strobe, 2: reset during the low phase.
  task automatic apply_word(input logic [15:0] w, input int mode);
    int guard;
    int wait_hi;
    bit strobe_exp;
    bit last;
    guard = 0;
    while (ioctl_wait && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check_output("wait_timeout_pre", 129'(1), 129'(0));
    words.push_back(w);
    last = (words.size() == 8);
    strobe_exp = 0;
    if (last) begin
      if (model_count < MAXC) begin
        exp_q.push_back('{rec: assemble(), cnt: model_count + 1});
        model_count++;
        strobe_exp = 1;
      end else begin
        model_overflow = 1;
      end
    end
    ioctl_dout = w;
    ioctl_wr = 1'b1;
    #1;
    if (last) check_output("wait_on_last_word", 129'(ioctl_wait), 129'(strobe_exp));
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    if (last) begin
      words.delete();
      if (strobe_exp && mode == 2) begin
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        ioctl_download = 1'b0;
        @(posedge clk); #1;
        check_output("rst_code", code, 129'(0));
        check_output("rst_wait", 129'(ioctl_wait), 129'(0));
        check_output("rst_count", 129'(code_count), 129'(0));
        check_output("rst_overflow", 129'(overflow), 129'(0));
        check_output("rst_codes_reset", 129'(codes_reset), 129'(0));
        reset = 1'b0;
        model_count = 0;
        model_overflow = 0;
      end else if (strobe_exp) begin
        if (mode == 1) begin
          cheat_clear = 1'b1;
          exp_clears++;
        end
        wait_hi = 0;
        guard = 0;
        @(negedge clk);
        while (ioctl_wait && guard < 50) begin
          wait_hi++;
          guard++;
          @(negedge clk);
        end
        check_output("wait_cycles", 129'(wait_hi), 129'(2 * STB));
        if (mode == 1) begin
          cheat_clear = 1'b0;
          model_count = 0;
          model_overflow = 0;
        end
      end
    end
  endtask

  task automatic apply_record(input int mode);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      apply_word(16'($urandom), (i == 7) ? mode : 0);
    end
  endtask

  task automatic start_download();
    @(posedge clk); #1;
    ioctl_download = 1'b1;
    exp_clears++;
    model_count = 0;
    model_overflow = 0;
    words.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic end_download();
    @(posedge clk); #1;
    ioctl_download = 1'b0;
    words.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic apply_clear_pulse();
    @(posedge clk); #1;
    cheat_clear = 1'b1;
    exp_clears++;
    model_count = 0;
    model_overflow = 0;
    words.delete();
    repeat (2) @(posedge clk);
    #1;
    cheat_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check_output({tag, "_count"}, 129'(code_count), 129'(model_count));
    check_output({tag, "_overflow"}, 129'(overflow), 129'(model_overflow));
    check_output({tag, "_clears"}, 129'(clr_pulses), 129'(exp_clears));
  endtask

  // Monitor: pops the expected record on each clock-bit rise and checks width/count on the fall.
  initial begin
    logic prev_bit;
    logic prev_cr;
    int   hi_cnt;
    bit   have_cur;
    exp_t cur;
    prev_bit = 1'b0;
    prev_cr = 1'b0;
    hi_cnt = 0;
    have_cur = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_bit = 1'b0;
        prev_cr = 1'b0;
        continue;
      end
      if (codes_reset) begin
        clr_pulses++;
        check_output("clear_pulse_isolated", 129'({prev_cr, ioctl_wait}), 129'(0));
      end
      prev_cr = codes_reset;
      if (code[128] && !prev_bit) begin
        strobes_seen++;
        hi_cnt = 1;
        if (exp_q.size() == 0) begin
          have_cur = 0;
          check_output("unexpected_strobe", 129'(1), 129'(0));
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
          check_output("strobe_record", 129'(code[127:0]), 129'(cur.rec));
        end
      end else if (code[128]) begin
        hi_cnt++;
      end else if (prev_bit) begin
        check_output("strobe_width", 129'(hi_cnt), 129'(STB));
        if (have_cur) check_output("count_after_strobe", 129'(code_count), 129'(cur.cnt));
      end
      prev_bit = code[128];
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [15:0] first_words[8];
    first_words = '{16'h0001, 16'h0000, 16'h1234, 16'h0000, 16'h00AB, 16'h0000, 16'h00CD, 16'h0000};

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_code", code, 129'(0));
    check_output("reset_wait", 129'(ioctl_wait), 129'(0));
    check_output("reset_count", 129'(code_count), 129'(0));
    check_output("reset_overflow", 129'(overflow), 129'(0));
    check_output("reset_codes_reset", 129'(codes_reset), 129'(0));
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] directed first record");
    start_download();
    for (int i = 0; i < 8; i++) apply_word(first_words[i], 0);
    check_output("first_record", 129'(code[127:0]), 129'({32'h1, 32'h1234, 32'hAB, 32'hCD}));
    check_model("first");
    end_download();

    $display("[TB] fill past capacity");
    start_download();
    base = strobes_seen;
    for (int r = 0; r < MAXC; r++) apply_record(0);
    check_model("full");
    apply_record(0);
    repeat (4) @(posedge clk);
    #1;
    check_model("overflowed");
    check_output("strobes_in_fill", 129'(strobes_seen - base), 129'(MAXC));
    apply_clear_pulse();
    check_model("clear_in_collect");

    $display("[TB] partial record dropped");
    apply_record(0);
    for (int i = 0; i < 3; i++) apply_word(16'($urandom), 0);
    end_download();
    check_output("idle_wait", 129'(ioctl_wait), 129'(0));
    start_download();
    apply_record(0);
    check_model("fresh_counter");

    $display("[TB] clear during strobe");
    apply_record(1);
    repeat (4) @(posedge clk);
    #1;
    check_model("clear_mid_strobe");

    $display("[TB] reset during low phase");
    apply_record(2);
    repeat (4) @(posedge clk);
    #1;
    check_output("post_reset_clears", 129'(clr_pulses), 129'(exp_clears));

    $display("[TB] download and clear together");
    @(posedge clk); #1;
    ioctl_download = 1'b1;
    cheat_clear = 1'b1;
    exp_clears++;
    model_count = 0;
    model_overflow = 0;
    words.delete();
    repeat (4) @(posedge clk);
    #1;
    cheat_clear = 1'b0;
    check_model("dual_edge");
    apply_record(0);
    check_model("dual_edge_record");
    end_download();

    check_output("scoreboard_empty", 129'(exp_q.size()), 129'(0));
    check_output("clock_bit_idle", 129'(code[128]), 129'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
